pooling_window_feeder: RTL and testbench

Upstream stage of pooling_max_cell. Accepts one convolution-layer feature map as a row-major stream of IEEE-754 single-precision words. Reorders the stream into consecutive 2x2, stride-2 pooling windows, one element per cycle. Buffers one even row in a line buffer and flags the first and last element of each window, so the max cell can restart its comparison on every window.

---
 rtl/pooling_window_feeder_if.sv | 24 ++
 rtl/pooling_window_feeder.sv | 126 ++++++++++++
 tb/tb_pooling_window_feeder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pooling_window_feeder_if.sv
// Stream interface between the pixel source, the window feeder and the max cell.
// The feeder takes the slave view; the pixel source / bench takes the master view.
interface pooling_window_feeder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_first;
  logic                  out_last;
  logic                  frame_done;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_data, out_first, out_last, frame_done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_data, out_first, out_last, frame_done
  );
endinterface

// File: rtl/pooling_window_feeder.sv
// Reorders a row-major feature-map stream into 2x2 stride-2 pooling windows,
// one element per cycle, with window first/last and end-of-frame markers.
//
// state | meaning
// FILL  | even row: pixels go into the line buffer
// ODD0  | odd row, even column: pixel goes to hold (bottom-left)
// ODD1  | odd row, odd column: pixel goes to cur (bottom-right), window starts
// EMIT  | four window elements presented, input stalled
module pooling_window_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int FM_WIDTH   = 8,
  parameter int FM_HEIGHT  = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  pooling_window_feeder_if.slave bus
);

  localparam int COL_W = $clog2(FM_WIDTH);
  localparam int ROW_W = $clog2(FM_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FM_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FM_HEIGHT - 1);

  typedef enum logic [1:0] {FILL, ODD0, ODD1, EMIT} state_t;

  state_t                state, state_next;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [1:0]            k;
  logic [COL_W-1:0]      win_col;
  logic                  last_win;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] cur;
  logic [DATA_WIDTH-1:0] line_buf [FM_WIDTH];
  logic                  accept;

  assign bus.in_ready = (state != EMIT);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL: if (accept && col == COL_LAST) state_next = ODD0;
      ODD0: if (accept) state_next = ODD1;
      ODD1: if (accept) state_next = EMIT;
      EMIT: if (k == 2'd3) state_next = (win_col == COL_LAST) ? FILL : ODD0;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k        <= '0;
      win_col  <= '0;
      last_win <= 1'b0;
      hold     <= '0;
      cur      <= '0;
    end else begin
      k <= (state == EMIT) ? k + 2'd1 : 2'd0;
      if (state == ODD0 && accept) hold <= bus.in_data;
      if (state == ODD1 && accept) begin
        cur      <= bus.in_data;
        win_col  <= col;
        last_win <= (col == COL_LAST) && (row == ROW_LAST);
      end
    end
  end

  // Line buffer needs no reset: every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (state == FILL && accept) line_buf[col] <= bus.in_data;
  end

  // Outputs are registered one element ahead: the ODD1 accept edge loads
  // element 0, and each EMIT cycle k loads element k+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_first  <= 1'b0;
      bus.out_last   <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.out_data   <= '0;
    end else begin
      bus.out_valid  <= 1'b0;
      bus.out_first  <= 1'b0;
      bus.out_last   <= 1'b0;
      bus.frame_done <= 1'b0;
      if (state == ODD1 && accept) begin
        bus.out_valid <= 1'b1;
        bus.out_first <= 1'b1;
        bus.out_data  <= line_buf[col - COL_W'(1)];
      end else if (state == EMIT && k != 2'd3) begin
        bus.out_valid <= 1'b1;
        case (k)
          2'd0:    bus.out_data <= line_buf[win_col];
          2'd1:    bus.out_data <= hold;
          default: begin
            bus.out_data   <= cur;
            bus.out_last   <= 1'b1;
            bus.frame_done <= last_win;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pooling_window_feeder.sv
// Directed bench for pooling_window_feeder on a 4x4 feature map.
// Checks window order, markers, stalls, bubbles, async reset and a max-cell model.
module tb_pooling_window_feeder;

  localparam int DW = 32;
  localparam int FW = 4;
  localparam int FH = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] pix     [16];
  logic [31:0] exp_win [16];
  logic [31:0] win0_max;

  pooling_window_feeder_if #(.DATA_WIDTH(DW)) bus ();

  pooling_window_feeder #(
    .DATA_WIDTH(DW),
    .FM_WIDTH  (FW),
    .FM_HEIGHT (FH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic run_frames(input int nframes, input bit gaps, input bit chk_row0);
    int p, e, cyc, low, done_cnt, total;
    bit drv;
    logic [31:0] mx;
    p = 0; e = 0; cyc = 0; low = 0; done_cnt = 0; mx = '0;
    total = nframes * 16;
    while (e < total && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (!bus.in_ready) low++;
      if (bus.out_valid) begin
        check("data",  bus.out_data, exp_win[e % 16]);
        check("first", 32'(bus.out_first), 32'(e % 4 == 0));
        check("last",  32'(bus.out_last), 32'(e % 4 == 3));
        check("done",  32'(bus.frame_done), 32'(e % 16 == 15));
        if (bus.frame_done) done_cnt++;
        if (bus.out_first) mx = bus.out_data;
        else if (bus.out_data > mx) mx = bus.out_data;
        if (e == 3) win0_max = mx;
        e++;
      end else begin
        check("idle_flags", 32'({bus.out_first, bus.out_last, bus.frame_done}), 32'd0);
      end
      if (chk_row0 && p <= FW) begin
        check("row0_valid", 32'(bus.out_valid), 32'd0);
        check("row0_ready", 32'(bus.in_ready), 32'd1);
      end
      drv = (p < total) && (!gaps || (cyc % 2 == 1));
      bus.in_valid = drv;
      bus.in_data  = drv ? pix[p % 16] : 32'hDEADBEEF;
      if (drv && bus.in_ready) p++;
    end
    bus.in_valid = 1'b0;
    check("timeout",   32'(e), 32'(total));
    check("ready_low", 32'(low), 32'(total));
    check("done_cnt",  32'(done_cnt), 32'(nframes));
  endtask

  task automatic load_ramp();
    pix = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
            32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
            32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
    exp_win = '{32'h3F800000, 32'h40000000, 32'h40A00000, 32'h40C00000,
                32'h40400000, 32'h40800000, 32'h40E00000, 32'h41000000,
                32'h41100000, 32'h41200000, 32'h41500000, 32'h41600000,
                32'h41300000, 32'h41400000, 32'h41700000, 32'h41800000};
  endtask

  initial begin
    int p;
    bit found;
    checks = 0; errors = 0; win0_max = '0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // reset state
    @(negedge clk);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data",  bus.out_data, 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_done",  32'(bus.frame_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single frame, continuous input, row 0 quiet
    load_ramp();
    run_frames(1, 1'b0, 1'b1);

    // bubbles every other cycle
    run_frames(1, 1'b1, 1'b0);

    // two frames back to back
    run_frames(2, 1'b0, 1'b0);

    // reset during EMIT k=1
    p = 0; found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_first) begin
        found = 1'b1;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = pix[p % 16];
        if (bus.in_ready) p++;
      end
    end
    bus.in_valid = 1'b0;
    check("emit_reached", 32'(found), 32'd1);
    check("emit_k0_data", bus.out_data, 32'h3F800000);
    @(negedge clk);
    check("emit_k1_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_data",  bus.out_data, 32'd0);
    check("arst_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_frames(1, 1'b0, 1'b1);

    // max-cell model fed from the window stream
    for (int i = 0; i < 16; i++) pix[i] = 32'(i + 1);
    pix[0] = 32'h3F000000;
    pix[1] = 32'h3F800000;
    pix[4] = 32'h41C80000;
    pix[5] = 32'h41400000;
    for (int w = 0; w < 4; w++) begin
      int base;
      base = (w / 2) * 2 * FW + (w % 2) * 2;
      exp_win[4*w]     = pix[base];
      exp_win[4*w + 1] = pix[base + 1];
      exp_win[4*w + 2] = pix[base + FW];
      exp_win[4*w + 3] = pix[base + FW + 1];
    end
    run_frames(1, 1'b0, 1'b0);
    check("max_cell", win0_max, 32'h41C80000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
